// File: rtl/sound_sequencer.sv
// rtl/sound_sequencer.sv - two-jingle square-wave sound sequencer driving a DAC sample stream
// Optional inter-note silence is built only when macro SND_GAP_EN is defined.
module sound_sequencer #(
    parameter int             N        = 8,
    parameter int             CLK_DIV  = 4,
    parameter int             NOTE_LEN = 2,
    parameter logic [N-1:0]   AMP      = {N{1'b1}},
    parameter int             GAP_LEN  = 1
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic         play_eat,
    input  logic         play_crash,
    output logic         sample_tick,
    output logic [N-1:0] dac_out,
    output logic         busy,
    output logic         done
);

    localparam int PW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int MAXL = (NOTE_LEN > GAP_LEN) ? NOTE_LEN : GAP_LEN;
    localparam int TW   = $clog2(MAXL + 1);

`ifdef SND_GAP_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NOTE = 2'd1,
        S_GAP  = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_NOTE = 1'b1
    } state_t;
`endif

    state_t          state;
    state_t          next_state;
    logic            jingle;      // 0 = eat, 1 = crash
    logic [1:0]      note_idx;
    logic [PW-1:0]   presc;
    logic [N-1:0]    phase;
    logic [TW-1:0]   tick_cnt;

    logic            tick;
    logic            last_note;
    logic            note_end;
    logic            preempt;
    logic            load;
    logic            adv;
    logic            finish;
    logic [N-1:0]    step;
    logic [N-1:0]    phase_sum;
`ifdef SND_GAP_EN
    logic            gap_end;
    logic            to_gap;
`endif

    function automatic logic [N-1:0] step_of(input logic crash, input logic [1:0] idx);
        logic [N-1:0] s;
        if (crash) begin
            case (idx)
                2'd0:    s = N'(128);
                2'd1:    s = N'(64);
                default: s = N'(32);
            endcase
        end else begin
            s = (idx == 2'd0) ? N'(16) : N'(32);
        end
        return s;
    endfunction

    assign tick      = (state != S_IDLE) && (presc == PW'(CLK_DIV - 1));
    assign last_note = jingle ? (note_idx == 2'd2) : (note_idx == 2'd1);
    assign note_end  = (state == S_NOTE) && tick && (tick_cnt == TW'(NOTE_LEN - 1));
    assign preempt   = (state != S_IDLE) && !jingle && play_crash;
    assign step      = step_of(jingle, note_idx);
    assign phase_sum = phase + step;
`ifdef SND_GAP_EN
    assign gap_end   = (state == S_GAP) && tick && (tick_cnt == TW'(GAP_LEN - 1));
`endif

    assign sample_tick = tick;
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A crash request during eat outranks the end-of-note decision, so no done slips out.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        adv        = 1'b0;
        finish     = 1'b0;
        done       = 1'b0;
`ifdef SND_GAP_EN
        to_gap     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (play_eat || play_crash) begin
                    next_state = S_NOTE;
                    load       = 1'b1;
                end
            end
            S_NOTE: begin
                if (preempt) begin
                    next_state = S_NOTE;
                    load       = 1'b1;
                end else if (note_end) begin
                    if (last_note) begin
                        next_state = S_IDLE;
                        finish     = 1'b1;
                        done       = 1'b1;
                    end else begin
`ifdef SND_GAP_EN
                        next_state = S_GAP;
                        to_gap     = 1'b1;
`else
                        next_state = S_NOTE;
                        adv        = 1'b1;
`endif
                    end
                end
            end
`ifdef SND_GAP_EN
            S_GAP: begin
                if (preempt) begin
                    next_state = S_NOTE;
                    load       = 1'b1;
                end else if (gap_end) begin
                    next_state = S_NOTE;
                    adv        = 1'b1;
                end
            end
`endif
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            jingle   <= 1'b0;
            note_idx <= 2'd0;
            presc    <= '0;
            phase    <= '0;
            tick_cnt <= '0;
            dac_out  <= '0;
        end else if (load) begin
            jingle   <= play_crash;
            note_idx <= 2'd0;
            presc    <= '0;
            phase    <= '0;
            tick_cnt <= '0;
            dac_out  <= '0;
        end else if (state == S_IDLE) begin
            presc    <= '0;
            dac_out  <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (adv) begin
                note_idx <= note_idx + 2'd1;
                phase    <= '0;
                tick_cnt <= '0;
                dac_out  <= '0;
            end else if (finish) begin
                note_idx <= 2'd0;
                phase    <= '0;
                tick_cnt <= '0;
                dac_out  <= '0;
`ifdef SND_GAP_EN
            end else if (to_gap) begin
                phase    <= phase_sum;
                tick_cnt <= '0;
                dac_out  <= '0;
            end else if (state == S_GAP) begin
                if (tick) begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
                dac_out <= '0;
`endif
            end else if (tick) begin
                phase    <= phase_sum;
                tick_cnt <= tick_cnt + TW'(1);
                dac_out  <= phase_sum[N-1] ? AMP : '0;
            end
        end
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// tb/tb_sound_sequencer.sv - table-driven checks of jingle timing, priority, restart and reset
module tb_sound_sequencer;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       play_eat = 1'b0;
    logic       play_crash = 1'b0;
    logic       sample_tick;
    logic [7:0] dac_out;
    logic       busy;
    logic       done;

`ifdef SND_GAP_EN
    localparam int GAPX = 1;
`else
    localparam int GAPX = 0;
`endif
    localparam int EAT_BUSY    = 16 + 4 * GAPX;
    localparam int CRASH_BUSY  = 24 + 8 * GAPX;
    localparam int EAT_TICKS   = 4 + GAPX;
    localparam int CRASH_TICKS = 6 + 2 * GAPX;

    sound_sequencer dut (
        .clk         (clk),
        .nRst        (nRst),
        .play_eat    (play_eat),
        .play_crash  (play_crash),
        .sample_tick (sample_tick),
        .dac_out     (dac_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       e;
        logic       c;
        int         inj_at;
        logic       inj_e;
        logic       inj_c;
        logic       sp_chk;
        int         exp_busy;
        int         exp_ticks;
        logic [7:0] exp_d1;
        logic [7:0] exp_d2;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v, input string tag);
        int         busy_n, tick_n, done_n, first_tick, last_tick, done_cyc, pend;
        logic [7:0] d1, d2;
        logic       sp_ok, dt_ok;
        busy_n = 0; tick_n = 0; done_n = 0; first_tick = 0; last_tick = 0;
        done_cyc = -1; pend = 0; d1 = 'x; d2 = 'x; sp_ok = 1'b1; dt_ok = 1'b1;
        @(negedge clk);
        play_eat = v.e; play_crash = v.c;
        @(negedge clk);
        play_eat = 1'b0; play_crash = 1'b0;
        while (busy === 1'b1 && busy_n < 200) begin
            busy_n++;
            if (pend == 1) d1 = dac_out;
            if (pend == 2) d2 = dac_out;
            pend = 0;
            if (sample_tick === 1'b1) begin
                tick_n++;
                if (tick_n == 1) first_tick = busy_n;
                else if (busy_n - last_tick != 4) sp_ok = 1'b0;
                last_tick = busy_n;
                pend = tick_n;
            end
            if (done === 1'b1) begin
                done_n++;
                done_cyc = busy_n;
                if (sample_tick !== 1'b1) dt_ok = 1'b0;
            end
            play_eat   = (busy_n == v.inj_at) && v.inj_e;
            play_crash = (busy_n == v.inj_at) && v.inj_c;
            @(negedge clk);
        end
        play_eat = 1'b0; play_crash = 1'b0;
        if (done_cyc != busy_n) dt_ok = 1'b0;
        check({tag, "_busy_len"}, busy_n, v.exp_busy);
        check({tag, "_ticks"}, tick_n, v.exp_ticks);
        check({tag, "_done_count"}, done_n, 1);
        check({tag, "_done_on_last_tick"}, {31'd0, dt_ok}, 1);
        check({tag, "_first_tick_cycle"}, first_tick, 4);
        check({tag, "_dac_after_t1"}, {24'd0, d1}, {24'd0, v.exp_d1});
        check({tag, "_dac_after_t2"}, {24'd0, d2}, {24'd0, v.exp_d2});
        if (v.sp_chk) check({tag, "_tick_spacing"}, {31'd0, sp_ok}, 1);
        check({tag, "_idle_dac"}, {24'd0, dac_out}, 0);
        check({tag, "_idle_tick"}, {31'd0, sample_tick}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_ticks, idle_busy, rst_done;
        //          e     c     inj  ie    ic    sp    busy              ticks                d1     d2
        vecs[0] = '{1'b1, 1'b0, 0,  1'b0, 1'b0, 1'b1, EAT_BUSY,         EAT_TICKS,       8'h00, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 0,  1'b0, 1'b0, 1'b1, CRASH_BUSY,       CRASH_TICKS,     8'hFF, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 0,  1'b0, 1'b0, 1'b1, CRASH_BUSY,       CRASH_TICKS,     8'hFF, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 5,  1'b1, 1'b0, 1'b1, CRASH_BUSY,       CRASH_TICKS,     8'hFF, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 6,  1'b0, 1'b1, 1'b0, 6 + CRASH_BUSY,   1 + CRASH_TICKS, 8'h00, 8'hFF};
        vecs[5] = '{1'b1, 1'b0, 3,  1'b1, 1'b0, 1'b1, EAT_BUSY,         EAT_TICKS,       8'h00, 8'h00};
        vecs[6] = '{1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b1, CRASH_BUSY,       CRASH_TICKS,     8'hFF, 8'h00};

        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_dac", {24'd0, dac_out}, 0);
        check("reset_tick", {31'd0, sample_tick}, 0);
        check("reset_done", {31'd0, done}, 0);
        nRst = 1'b1;

        idle_ticks = 0; idle_busy = 0;
        repeat (8) begin
            @(negedge clk);
            if (sample_tick === 1'b1) idle_ticks++;
            if (busy === 1'b1) idle_busy++;
        end
        check("idle_no_ticks", idle_ticks, 0);
        check("idle_not_busy", idle_busy, 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
            repeat (2) @(negedge clk);
        end

        // Reset in the middle of a crash jingle, while dac_out is high.
        @(negedge clk);
        play_crash = 1'b1;
        @(negedge clk);
        play_crash = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_busy", {31'd0, busy}, 1);
        check("pre_reset_dac", {24'd0, dac_out}, 32'hFF);
        #2 nRst = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 0);
        check("async_rst_dac", {24'd0, dac_out}, 0);
        check("async_rst_tick", {31'd0, sample_tick}, 0);
        check("async_rst_done", {31'd0, done}, 0);
        rst_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) rst_done++;
        end
        nRst = 1'b1;
        idle_busy = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0) idle_busy++;
            if (done !== 1'b0) rst_done++;
        end
        check("post_rst_no_done", rst_done, 0);
        check("post_rst_waits", idle_busy, 0);
        run_vec(vecs[0], "post_rst_eat");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sound_sequencer.md
SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 Parameter N, default 8: DAC sample width and phase accumulator width, in bits.
REQ-002 Parameter CLK_DIV, default 4: clock cycles per sample tick; legal values are 2 or more.
REQ-003 Parameter NOTE_LEN, default 2: sample ticks per note; legal values are 1 or more.
REQ-004 Parameter AMP, default all-ones of N bits: DAC high level.
REQ-005 Parameter GAP_LEN, default 1: sample ticks per silent gap; used only when SND_GAP_EN is defined.
REQ-006 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 Port nRst, input, 1 bit: reset, asynchronous assert, active-low.
REQ-008 Port play_eat, input, 1 bit: one-cycle request for the eat jingle.
REQ-009 Port play_crash, input, 1 bit: one-cycle request for the crash jingle.
REQ-010 Port sample_tick, output, 1 bit: one-cycle sample strobe; drives the at_max input of the downstream DAC sample counter.
REQ-011 Port dac_out, output, N bits: current DAC sample.
REQ-012 Port busy, output, 1 bit: high while a jingle is playing.
REQ-013 Port done, output, 1 bit: one-cycle pulse when a jingle completes.

Function
REQ-014 The FSM SHALL have states IDLE, NOTE, and GAP; GAP SHALL exist only when SND_GAP_EN is defined.
REQ-015 Jingle tables SHALL be: eat = phase steps {16, 32}; crash = phase steps {128, 64, 32}.
REQ-016 In IDLE, a request sampled at an edge SHALL load jingle and note index 0, clear prescaler and phase, and enter NOTE; busy rises in the next cycle.
REQ-017 If play_eat and play_crash are high in the same cycle, the sequencer SHALL select crash.
REQ-018 play_crash in NOTE or GAP during an eat jingle SHALL restart at crash note 0, clearing prescaler, phase and tick count, with no done pulse.
REQ-019 All other requests while busy SHALL be ignored.
REQ-020 Prescaler: counts 0..CLK_DIV-1 in NOTE/GAP, wraps to 0; sample_tick is high exactly when the prescaler equals CLK_DIV-1. First tick comes CLK_DIV cycles after entering NOTE.
REQ-021 The prescaler SHALL be held at 0 in IDLE, and sample_tick SHALL be low in IDLE.
REQ-022 Phase (N bits): on each sample_tick in NOTE, phase SHALL become phase + step mod 2^N; phase SHALL clear to 0 at every note start.
REQ-023 dac_out SHALL be registered, equal to AMP when phase MSB is 1 and 0 otherwise, updated with the phase; dac_out SHALL be 0 in IDLE and GAP.
REQ-024 On the NOTE_LEN-th tick of a note that is not the last, the FSM SHALL go to GAP when the macro is defined, otherwise straight to the next note's NOTE.
REQ-025 On the NOTE_LEN-th tick of the last note, the FSM SHALL go to IDLE and assert done for exactly that one cycle.
REQ-026 busy SHALL be high whenever the state is not IDLE.

Reset
REQ-027 While nRst is low, the FSM SHALL be IDLE and prescaler, phase, note index, tick count, sample_tick, dac_out, busy and done SHALL all be 0.
REQ-028 A reset asserted mid-jingle SHALL abort it immediately with no done pulse; after release, the block waits for a new request.

Configuration
REQ-029 With macro SND_GAP_EN defined, a GAP state of GAP_LEN ticks SHALL separate consecutive notes, with dac_out 0 and phase held.
REQ-030 With SND_GAP_EN undefined, notes SHALL play back-to-back and no GAP logic SHALL be synthesized.

Verification (defaults, SND_GAP_EN undefined unless stated)
REQ-031 play_eat pulse -> busy high for 16 cycles, 4 sample_ticks spaced 4 cycles apart, done pulse on the 4th tick cycle.
REQ-032 play_crash pulse -> dac_out AMP after tick 1, 0 after tick 2 (phase 128 then 0); busy lasts 24 cycles; 6 ticks.
REQ-033 play_eat and play_crash in the same cycle -> crash sequence with 24-cycle busy; play_eat mid-crash -> no change.
REQ-034 play_crash 6 cycles into eat -> restart; busy lasts 6+24 cycles total; exactly one done pulse.
REQ-035 nRst low 5 cycles into crash -> all outputs 0 asynchronously, no done; the next play_eat behaves as in REQ-031.
REQ-036 SND_GAP_EN with GAP_LEN=1 -> eat busy lasts 20 cycles, crash 32; dac_out is 0 during gaps.
